rr_pipe_arbiter: RTL

- Round-robin burst arbiter. Shares one two-stage registered datapath (stage1 register, then output register) between NREQ requesters.
- Selects one owner, streams up to MAX_BURST beats from it, then rotates priority to the next requester.
- Tags every beat with the source ID so downstream logic can demultiplex.
- Sits between requester ports and any single-consumer registered pipeline.

---
 rtl/rr_pipe_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/rr_pipe_arbiter.sv
// Round-robin burst arbiter feeding a two-stage registered datapath, beats tagged with source ID.
// Optional output backpressure (out_ready port) is enabled by defining PIPE_ARB_STALL_EN.
module rr_pipe_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned DW        = 8,
    parameter int unsigned IDW       = 2,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   in_data,
    input  logic                 flush,
`ifdef PIPE_ARB_STALL_EN
    input  logic                 out_ready,
`endif
    output logic [NREQ-1:0]      gnt,
    output logic                 out_valid,
    output logic [DW-1:0]        out_data,
    output logic [IDW-1:0]       out_id,
    output logic                 busy
);

    localparam int unsigned CW = 8;
    localparam int unsigned PW = IDW + 1;
    localparam logic [CW-1:0] MAXB = CW'(MAX_BURST);

    typedef enum logic {S_IDLE, S_OWN} state_t;

    state_t          state, state_nxt;
    logic [IDW-1:0]  rr_ptr, rr_ptr_nxt;
    logic [IDW-1:0]  owner, owner_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [NREQ-1:0] gnt_c;
    logic [IDW-1:0]  win;
    logic            win_found;
    logic [PW-1:0]   scan_idx;
    logic [DW-1:0]   sel_data;
    logic [IDW-1:0]  sel_id;
    logic            accept;
    logic            stall;
    logic            s1_valid;
    logic [DW-1:0]   s1_data;
    logic [IDW-1:0]  s1_id;

`ifdef PIPE_ARB_STALL_EN
    assign stall = out_valid & ~out_ready;
`else
    assign stall = 1'b0;
`endif

    function automatic logic [IDW-1:0] inc_wrap(input logic [IDW-1:0] i);
        return (32'(i) == NREQ - 1) ? '0 : i + 1'b1;
    endfunction

    // First requester at or after rr_ptr, wrapping modulo NREQ
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        scan_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = PW'(rr_ptr) + PW'(k);
            if (scan_idx >= PW'(NREQ))
                scan_idx = scan_idx - PW'(NREQ);
            if (!win_found && req[IDW'(scan_idx)]) begin
                win       = IDW'(scan_idx);
                win_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= S_IDLE;
            rr_ptr <= '0;
            owner  <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_ptr_nxt;
            owner  <= owner_nxt;
            cnt    <= cnt_nxt;
        end
    end

    // Ownership FSM: flush beats stall, and a stalled cycle holds everything
    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        owner_nxt  = owner;
        cnt_nxt    = cnt;
        gnt_c      = '0;
        if (flush) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
        end else if (!stall) begin
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        gnt_c[win] = 1'b1;
                        if (MAX_BURST == 1) begin
                            rr_ptr_nxt = inc_wrap(win);
                        end else begin
                            state_nxt = S_OWN;
                            owner_nxt = win;
                            cnt_nxt   = CW'(1);
                        end
                    end
                end
                S_OWN: begin
                    if (req[owner]) begin
                        gnt_c[owner] = 1'b1;
                        cnt_nxt      = cnt + CW'(1);
                        if (cnt + CW'(1) == MAXB) begin
                            state_nxt  = S_IDLE;
                            rr_ptr_nxt = inc_wrap(owner);
                        end
                    end else begin
                        state_nxt  = S_IDLE;
                        rr_ptr_nxt = inc_wrap(owner);
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    assign gnt    = gnt_c & {NREQ{rstn}};
    assign accept = |gnt;

    // Granted slice and its index; zero when nothing is granted
    always_comb begin
        sel_data = '0;
        sel_id   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_c[i]) begin
                sel_data = sel_data | in_data[i*DW +: DW];
                sel_id   = sel_id | IDW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_id     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
        end else if (flush || !stall) begin
            s1_valid  <= accept;
            s1_data   <= sel_data;
            s1_id     <= sel_id;
            out_valid <= s1_valid & ~flush;
            out_data  <= s1_data;
            out_id    <= s1_id;
        end
    end

    assign busy = (state == S_OWN) | s1_valid | out_valid;

endmodule
